// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding, byte width and the default
// target address used by both the controller and the target receiver.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] I2C_DEFAULT_ADDR = 8'hA9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ADDR,
    RX_DATA,
    RX_SKIP,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/i2c_rx_shreg.sv
// Serial-in/parallel-out byte shifter with a bit counter. par_byte is the byte
// as it will stand once the current sda bit is shifted in.
module i2c_rx_shreg #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              shift_en,
  input  logic              clr,
  output logic [BYTE_W-1:0] par_byte,
  output logic              byte_done
);

  localparam int unsigned CNT_W = $clog2(BYTE_W);

  // Only the low BYTE_W-1 bits are stored; the MSB leaves as the byte completes.
  logic [BYTE_W-2:0] sr;
  logic [CNT_W-1:0]  cnt;

  assign par_byte  = {sr, din};
  assign byte_done = shift_en && (cnt == CNT_W'(BYTE_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= par_byte[BYTE_W-2:0];
      cnt <= byte_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_target_rx.sv
// Target-side I2C byte receiver: start detect, address compare, data capture.
// Optional stop-slot check enabled by defining I2C_TARGET_RX_STOP_CHECK_EN.
module i2c_target_rx #(
  parameter logic [7:0]  OWN_ADDR = i2c_pkg::I2C_DEFAULT_ADDR,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sda,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic [BYTE_W-1:0] addr_out,
  output logic              addr_match,
  output logic              busy,
  output logic              frame_err
);

  import i2c_pkg::*;

  rx_state_t         state, state_d;
  logic              sda_q;
  logic              shift_en, clr;
  logic [BYTE_W-1:0] par_byte;
  logic              byte_done;

  logic [BYTE_W-1:0] addr_out_d, data_out_d;
  logic              addr_match_d, data_valid_d;

  i2c_rx_shreg #(
    .BYTE_W(BYTE_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (sda),
    .shift_en (shift_en),
    .clr      (clr),
    .par_byte (par_byte),
    .byte_done(byte_done)
  );

`ifdef I2C_TARGET_RX_STOP_CHECK_EN
  logic [BYTE_W-1:0] data_pend, data_pend_d;
  logic              frame_err_q, frame_err_d;

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d      = state;
    shift_en     = 1'b0;
    clr          = 1'b0;
    addr_out_d   = addr_out;
    addr_match_d = addr_match;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
`ifdef I2C_TARGET_RX_STOP_CHECK_EN
    data_pend_d  = data_pend;
    frame_err_d  = 1'b0;
`endif
    unique case (state)
      RX_IDLE: begin
        if (sda_q && !sda) begin
          state_d = RX_ADDR;
          clr     = 1'b1;
        end
      end
      RX_ADDR: begin
        shift_en = 1'b1;
        if (byte_done) begin
          addr_out_d = par_byte;
          if (par_byte == OWN_ADDR) begin
            addr_match_d = 1'b1;
            state_d      = RX_DATA;
          end else begin
            addr_match_d = 1'b0;
            state_d      = RX_SKIP;
          end
        end
      end
      RX_DATA: begin
        shift_en = 1'b1;
        if (byte_done) begin
`ifdef I2C_TARGET_RX_STOP_CHECK_EN
          data_pend_d = par_byte;
          state_d     = RX_STOP;
`else
          data_out_d   = par_byte;
          data_valid_d = 1'b1;
          addr_match_d = 1'b0;
          state_d      = RX_IDLE;
`endif
        end
      end
      RX_SKIP: begin
        shift_en = 1'b1;
        if (byte_done) begin
`ifdef I2C_TARGET_RX_STOP_CHECK_EN
          state_d = RX_STOP;
`else
          state_d = RX_IDLE;
`endif
        end
      end
`ifdef I2C_TARGET_RX_STOP_CHECK_EN
      RX_STOP: begin
        // addr_match still distinguishes a data frame from a skipped one here
        if (!sda) begin
          frame_err_d = 1'b1;
        end else if (addr_match) begin
          data_out_d   = data_pend;
          data_valid_d = 1'b1;
        end
        addr_match_d = 1'b0;
        state_d      = RX_IDLE;
      end
`endif
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      sda_q      <= 1'b0;
      addr_out   <= '0;
      addr_match <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sda_q      <= sda;
      addr_out   <= addr_out_d;
      addr_match <= addr_match_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      busy       <= (state_d != RX_IDLE);
    end
  end

`ifdef I2C_TARGET_RX_STOP_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pend   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      data_pend   <= data_pend_d;
      frame_err_q <= frame_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: directed frames plus random frames
// compared against a frame-level model of what the target should report.
module tb_i2c_target_rx;

  localparam logic [7:0] OWN = 8'hA9;

`ifdef I2C_TARGET_RX_STOP_CHECK_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda = 1'b0;
  logic [7:0] data_out, addr_out;
  logic       data_valid, addr_match, busy, frame_err;

  int tests = 0;
  int fails = 0;

  // model state: last data byte the target should have accepted
  logic [7:0] exp_data = 8'h00;

  i2c_target_rx #(
    .OWN_ADDR(OWN),
    .BYTE_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sda       (sda),
    .data_out  (data_out),
    .data_valid(data_valid),
    .addr_out  (addr_out),
    .addr_match(addr_match),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends start, address, data, stop slot and one idle-high cycle.
  // Entry condition: sda high and sampled high for at least one cycle.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input bit stop_ok);
    bit match, accept, err;
    int pulses;
    match  = (a == OWN);
    err    = STOP_EN && !stop_ok;
    accept = match && !err;
    pulses = 0;

    sda = 1'b0;
    step();
    check("busy_at_start", 8'(busy), 8'd1);
    for (int i = 7; i >= 0; i--) begin
      sda = a[i];
      step();
      pulses += int'(data_valid);
    end
    check("addr_out", addr_out, a);
    check("addr_match", 8'(addr_match), 8'(match));
    check("busy_after_addr", 8'(busy), 8'd1);
    for (int i = 7; i >= 1; i--) begin
      sda = d[i];
      step();
      pulses += int'(data_valid);
    end
    check("no_early_valid", 8'(pulses), 8'd0);
    sda = d[0];
    step();
    if (accept) exp_data = d;
    if (!STOP_EN) begin
      check("valid_at_T16", 8'(data_valid), 8'(accept));
      check("data_out_T16", data_out, exp_data);
      check("busy_after_T16", 8'(busy), 8'd0);
      check("match_clear_T16", 8'(addr_match), 8'd0);
      sda = 1'b1;
      step();
    end else begin
      check("no_valid_T16", 8'(data_valid), 8'd0);
      check("busy_in_stop", 8'(busy), 8'd1);
      sda = stop_ok;
      step();
      check("valid_at_T17", 8'(data_valid), 8'(accept));
      check("frame_err_T17", 8'(frame_err), 8'(err));
      check("data_out_T17", data_out, exp_data);
      check("busy_after_T17", 8'(busy), 8'd0);
      check("match_clear_T17", 8'(addr_match), 8'd0);
      sda = 1'b1;
      step();
    end
    check("valid_one_cycle", 8'(data_valid), 8'd0);
    check("frame_err_clear", 8'(frame_err), 8'd0);
    check("idle_not_busy", 8'(busy), 8'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, 8'h00);
    check({tag, "_addr_out"}, addr_out, 8'h00);
    check({tag, "_flags"}, {3'b0, data_valid, addr_match, busy, frame_err, 1'b0}, 8'h00);
  endtask

  initial begin
    logic [7:0] ra, rd;
    bit rs;

    // reset, then sda held low: a low level alone must not start a frame
    rst_n = 1'b0;
    sda   = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_start_low_level", 8'(busy), 8'd0);
    end
    sda = 1'b1;
    step();
    check("no_start_high", 8'(busy), 8'd0);

    send_frame(OWN, 8'h3C, 1'b1);
    send_frame(8'h55, 8'hFF, 1'b1);
    send_frame(OWN, 8'h81, 1'b1);
    send_frame(OWN, 8'h7E, 1'b1);

    // reset asserted while the 4th data bit is on the line
    sda = 1'b0;
    step();
    for (int i = 7; i >= 0; i--) begin
      sda = OWN[i];
      step();
    end
    for (int i = 7; i >= 5; i--) begin
      sda = 1'b1;
      step();
    end
    sda   = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_data = 8'h00;
    step();
    rst_n = 1'b1;
    sda   = 1'b1;
    step();
    check("post_reset_idle", 8'(busy), 8'd0);
    send_frame(OWN, 8'hA5, 1'b1);

    if (!STOP_EN) begin
      // frame ending in a 0 bit, then sda stays low: not a new start
      sda = 1'b0;
      step();
      for (int i = 7; i >= 0; i--) begin sda = OWN[i]; step(); end
      for (int i = 7; i >= 0; i--) begin sda = 1'b0; step(); end
      check("zero_byte_valid", 8'(data_valid), 8'd1);
      check("zero_byte_data", data_out, 8'h00);
      exp_data = 8'h00;
      step();
      check("no_start_after_low_bit", 8'(busy), 8'd0);
      sda = 1'b1;
      step();
      check("still_idle", 8'(busy), 8'd0);
    end else begin
      send_frame(OWN, 8'h12, 1'b0);
      send_frame(8'h33, 8'h44, 1'b0);
    end

    for (int n = 0; n < 12; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? OWN : 8'($urandom);
      rd = 8'($urandom);
      rs = STOP_EN ? bit'($urandom_range(0, 3) != 0) : 1'b1;
      send_frame(ra, rd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Receive-side counterpart of the team's serial I2C controller.
- Samples the single-wire sda stream and detects the start bit.
- Captures the 8-bit address byte (MSB first) and compares it against its own address.
- On a match, captures the following data byte and presents it on a parallel port with a one-cycle valid pulse.
- Sits on the target side of the bus, same clock domain as the controller; no synchroniser on sda.

Parameters:
- OWN_ADDR, 8'hA9, full 8-bit address byte (incl. R/W bit) this target responds to.
- BYTE_W, 8, bits per address/data byte; only 8 supported.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sda  input  1  serial line; idle high, one bit per clk.
- data_out  output  8  last accepted data byte; holds until the next accepted frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- addr_out  output  8  last address byte received, matching or not.
- addr_match  output  1  high from address compare until the end of the frame, when the address equals OWN_ADDR.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- frame_err  output  1  one-cycle pulse on stop violation; tied 0 without the optional feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; bit_cnt 0; sda_q 0.
  - sda_q = 0 at reset means a start is recognised only after sda has been observed high at least once.
- States: IDLE, ADDR, DATA, SKIP, STOP (STOP exists only with the optional feature).
- IDLE:
  - Start = sda_q==1 && sda==0 at a posedge (edge T).
  - On start: go to ADDR, bit_cnt <= 0.
  - A level-low sda with no prior high cycle is ignored.
- ADDR:
  - Address bits are sampled at edges T+1..T+8, MSB first, shifted into addr_sr.
  - At bit_cnt==7: addr_out <= {addr_sr[6:0], sda}, then bit_cnt <= 0.
  - If that byte equals OWN_ADDR: addr_match <= 1 and go to DATA.
  - Otherwise: addr_match <= 0 and go to SKIP.
- SKIP: count 8 bits (edges T+9..T+16), discard them, then IDLE. No data_valid.
- DATA: data bits are sampled at edges T+9..T+16. At bit_cnt==7:
  - Without the feature: data_out <= {data_sr[6:0], sda}, data_valid <= 1 for exactly one cycle (visible after edge T+16), addr_match <= 0, go to IDLE.
  - With the feature: go to STOP (see Optional Feature).
- Back-to-back frames: the next start needs sda high for ≥1 cycle after the last bit. The first IDLE-cycle sample of a low sda directly after a 0 last bit is not a start.
- busy tracks state != IDLE, registered; it is high from edge T to the return to IDLE.
- Reset asserted mid-frame: immediate return to reset values. Partial bytes are discarded; data_out/addr_out are cleared.
- sda is assumed stable for the full clk period. No glitch filtering; no output drive (no ACK).

Optional Feature:
- Macro: I2C_TARGET_RX_STOP_CHECK_EN.
- Defined:
  - After the last data bit, enter STOP; the stop slot is sampled at edge T+17.
  - sda==1 there: data_out updates and data_valid pulses (visible after T+17).
  - sda==0 there: data is discarded, frame_err pulses one cycle, data_out is unchanged.
  - Either way, go to IDLE with addr_match <= 0.
  - SKIP frames also pass through the stop check; a violation flags frame_err.
- Undefined: no STOP state, frame_err tied 0, timing as in Behaviour.

Decomposition:
- Shared package i2c_pkg:
  - rx_state_t enum {RX_IDLE, RX_ADDR, RX_DATA, RX_SKIP, RX_STOP}.
  - localparam BYTE_W = 8.
  - localparam I2C_DEFAULT_ADDR = 8'hA9, shared with the controller.
- One sub-module: i2c_rx_shreg, an 8-bit serial-in/parallel-out shifter with a 3-bit bit counter.
  - Inputs: shift_en, clr.
  - Outputs: parallel byte, byte_done.
  - Instanced once and reused for the address byte and the data byte.

Test Plan:
- Reset release with sda low for 5 cycles, then high for 1, then low → no start until the high→low; busy rises only after the falling edge.
- Idle high, start, address 10101001, data 0x3C → addr_out=0xA9, addr_match=1, data_out=0x3C, single data_valid pulse at T+16 (T+17 with stop check).
- Start, address 0x55, data 0xFF → addr_out=0x55, addr_match=0, no data_valid, data_out keeps its previous value, busy low after T+16.
- Two frames: data 0x81, then 1 idle-high cycle, then a frame with data 0x7E → two data_valid pulses; data_out 0x81 then 0x7E.
- rst_n pulsed low at the 4th data bit of a matching frame → all outputs 0, state IDLE; the next full frame with data 0xA5 is received correctly.
- With I2C_TARGET_RX_STOP_CHECK_EN: matching frame, data 0x12, sda held low in the stop slot → frame_err pulse, no data_valid, data_out unchanged.
